// File: rtl/serial_bit_source.sv
// rtl/serial_bit_source.sv - FIFO-buffered parallel-to-serial bit source with gapless word chaining
module serial_bit_source #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 4,
   parameter int LSB_FIRST = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       flush_i,
   input  logic [WIDTH-1:0]           data_i,
   input  logic                       valid_i,
   output logic                       ready_o,
   output logic                       d_o,
   output logic                       valid_o,
   output logic                       busy_o,
   output logic [$clog2(DEPTH):0]     count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int BW = $clog2(WIDTH);

   localparam logic [BW-1:0] LAST_BIT  = BW'(WIDTH - 1);
   localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] mem_d [DEPTH];

   logic [0:0]       state_q,   state_d;
   logic [PW-1:0]    wr_ptr_q,  wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q,  rd_ptr_d;
   logic [CW-1:0]    count_q,   count_d;
   logic [WIDTH-1:0] sr_q,      sr_d;
   logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
   logic             d_q,       d_d;
   logic             valid_q,   valid_d;

   logic             push;
   logic             pop;
   logic [WIDTH-1:0] head_word;

   // Acceptance depends only on the registered count, so a full FIFO refuses even when a pop coincides.
   assign ready_o   = (count_q != FULL_CNT);
   assign push      = valid_i && ready_o && !flush_i;
   assign head_word = mem_q[rd_ptr_q];

   assign d_o     = d_q;
   assign valid_o = valid_q;
   assign busy_o  = (state_q == ST_SHIFT);
   assign count_o = count_q;

   // Storage write: the accepted word lands at the write pointer.
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_d[i] = mem_q[i];
      end
      if (push) begin
         mem_d[wr_ptr_q] = data_i;
      end
   end

   // Shifter FSM, pointer and occupancy update; flush overrides everything else.
   always_comb begin
      state_d   = state_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      sr_d      = sr_q;
      bit_cnt_d = bit_cnt_q;
      d_d       = d_q;
      valid_d   = valid_q;
      pop       = 1'b0;

      if (flush_i) begin
         state_d   = ST_IDLE;
         wr_ptr_d  = '0;
         rd_ptr_d  = '0;
         count_d   = '0;
         bit_cnt_d = '0;
         d_d       = 1'b0;
         valid_d   = 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (count_q != '0) begin
                  pop = 1'b1;
               end else begin
                  valid_d = 1'b0;
                  d_d     = 1'b0;
               end
            end
            ST_SHIFT: begin
               if (bit_cnt_q == LAST_BIT) begin
                  // Chain straight into the next buffered word so the serial stream has no bubble.
                  if (count_q != '0) begin
                     pop = 1'b1;
                  end else begin
                     state_d   = ST_IDLE;
                     valid_d   = 1'b0;
                     d_d       = 1'b0;
                     bit_cnt_d = '0;
                  end
               end else begin
                  bit_cnt_d = bit_cnt_q + 1'b1;
                  valid_d   = 1'b1;
                  if (LSB_FIRST != 0) begin
                     sr_d = sr_q >> 1;
                     d_d  = sr_q[1];
                  end else begin
                     sr_d = sr_q << 1;
                     d_d  = sr_q[WIDTH-2];
                  end
               end
            end
            default: begin
               state_d = ST_IDLE;
               valid_d = 1'b0;
               d_d     = 1'b0;
            end
         endcase

         if (pop) begin
            state_d   = ST_SHIFT;
            sr_d      = head_word;
            bit_cnt_d = '0;
            valid_d   = 1'b1;
            d_d       = (LSB_FIRST != 0) ? head_word[0] : head_word[WIDTH-1];
            rd_ptr_d  = rd_ptr_q + 1'b1;
         end

         if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
         end

         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // FIFO storage has no reset; its contents are irrelevant until written.
   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         mem_q[i] <= mem_d[i];
      end
   end

   // Control and output registers, cleared asynchronously.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         sr_q      <= '0;
         bit_cnt_q <= '0;
         d_q       <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         sr_q      <= sr_d;
         bit_cnt_q <= bit_cnt_d;
         d_q       <= d_d;
         valid_q   <= valid_d;
      end
   end

endmodule

// File: doc/serial_bit_source.md
Name: serial_bit_source

Overview:
- Upstream feeder for the overlapping-pattern detector.
- Accepts parallel words over a valid/ready handshake and buffers them in a small FIFO.
- Shifts each word out one bit per clock as a d_o/valid_o pair. These connect directly to the detector's serial data and valid inputs.
- Consecutive buffered words are emitted back-to-back with no bubble, so overlapping patterns that span word boundaries stay detectable.

Parameters:
- WIDTH, 8, bits per parallel word (>=2).
- DEPTH, 4, FIFO entries (power of two, >=2).
- LSB_FIRST, 0, 0 = serialize MSB first, 1 = LSB first.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset).
- flush_i  input  1  synchronous clear: empties FIFO and aborts the current word.
- data_i  input  WIDTH  parallel word to serialize.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  FIFO can accept a word; equals !full, combinational from the registered count.
- d_o  output  1  serial bit, registered.
- valid_o  output  1  d_o is valid this cycle, registered.
- busy_o  output  1  shifter holds an in-progress word (state SHIFT).
- count_o  output  $clog2(DEPTH)+1  FIFO occupancy, registered.

Behaviour:
- Reset (rst=0, async) forces the following; the FIFO contents are don't-care.
  - d_o=0, valid_o=0, busy_o=0, count_o=0, ready_o=1.
  - State IDLE; FIFO read and write pointers 0; bit counter 0.
- Push occurs on an edge when valid_i && ready_o && !flush_i.
  - data_i is written at the write pointer; the write pointer increments and wraps modulo DEPTH.
  - valid_i while ready_o=0 is ignored; the word is dropped, and holding the word is the upstream's job.
- Pop occurs when the shifter loads a word.
  - It reads from the read pointer; the read pointer wraps modulo DEPTH.
  - A pop is only possible when count_o>0 (registered).
- Simultaneous push and pop in one edge leaves count_o unchanged.
- A full FIFO never accepts a push, even if a pop happens on the same edge (ready_o is from registered count only).
- FSM:
  - IDLE: if count_o>0, pop at next edge → SHIFT.
    - Load shift register.
    - d_o = first bit (MSB if LSB_FIRST=0, else LSB).
    - valid_o=1, bit counter=0.
    - Otherwise stay, with valid_o=0 and d_o=0.
  - SHIFT: each edge advances to the next bit; d_o = next bit, bit counter+1, valid_o stays 1.
  - SHIFT, edge after the last bit (bit counter = WIDTH-1):
    - If count_o>0 (including a word pushed on an earlier edge), pop and load the next word in the same edge. valid_o stays 1, with no gap.
    - Otherwise → IDLE, with valid_o=0 and d_o=0.
- Latency: a word pushed at edge E into an empty, idle block produces its first bit (valid_o=1) after edge E+1. Its last bit is after edge E+WIDTH.
- Throughput: exactly one bit per cycle while the FIFO is non-empty; the sustained word rate is 1 word per WIDTH cycles.
- flush_i=1 at an edge has priority over push, pop, and shift:
  - count_o=0, pointers 0, state IDLE.
  - valid_o=0, d_o=0, busy_o=0.
- Reset asserted mid-word aborts immediately (async). No partial word is resumed after release.
- count_o never exceeds DEPTH and never underflows.

Test Plan:
- Single word, WIDTH=8, MSB first:
  - Stimulus: reset, release, push 8'hB6 once.
  - Required: valid_o high for exactly 8 cycles starting one cycle after the push edge, then low.
  - Required: d_o sequence 1,0,1,1,0,1,1,0.
- Back-to-back words:
  - Stimulus: push 8'hFF then 8'h00 on consecutive edges.
  - Required: 16 contiguous valid_o cycles with no bubble; d_o = eight 1s then eight 0s; count_o peaks at 1.
- Full FIFO:
  - Stimulus: with DEPTH=4, push 6 words on consecutive edges (0x11..0x66).
  - Required: ready_o drops once count_o=4 and that push is refused.
  - Required: only accepted words appear on d_o, in order; 0x66, and any word offered while ready_o=0, never appears.
- Flush mid-word:
  - Stimulus: push 0xA5 and 0x3C; assert flush_i after 3 bits of 0xA5.
  - Required: valid_o=0 the next cycle, count_o=0, busy_o=0, and no bits of 0x3C emitted.
- Async reset mid-stream:
  - Stimulus: drop rst between clock edges during SHIFT.
  - Required: valid_o, d_o, busy_o, count_o all 0 immediately, without waiting for an edge; ready_o=1.
- Chained with the detector:
  - Stimulus: feed 600 random words; count the detector's pattern rising edges.
  - Required: the count equals a software model run over the same concatenated bitstream, including patterns that straddle word boundaries.
